// File: rtl/debounce_bank_pkg.sv
// Shared constants and helpers for the multi-channel input debouncer.
package debounce_bank_pkg;

  // Debounce window in ticks when tick is the shared 1 kHz strobe.
  localparam int DEBOUNCE_MS = 10;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ACT_RESTART = 3'd0,
    ACT_IDLE    = 3'd1,
    ACT_COMMIT  = 3'd2,
    ACT_COUNT   = 3'd3,
    ACT_HOLD    = 3'd4
  } dbc_action_e;

  // Counter width for a window of delay ticks; never narrower than one bit.
  function automatic int cnt_width(input int delay);
    return (delay > 2) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, candidate tracker, stability counter and
// registered level/edge outputs.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int   DELAY       = 16,
  parameter logic ACTIVE_LOW  = 1'b0,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   cand_q, cand_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s1_s;
  dbc_action_e            action_s;

  assign s1_s = sync_q[SYNC_STAGES-1];

  // A candidate change always wins, so any bounce restarts the window.
  always_comb begin
    action_s = ACT_HOLD;
    if (s1_s != cand_q) begin
      action_s = ACT_RESTART;
    end else if (cand_q == clean_q) begin
      action_s = ACT_IDLE;
    end else if (tick && (count_q == CNT_LAST)) begin
      action_s = ACT_COMMIT;
    end else if (tick) begin
      action_s = ACT_COUNT;
    end else begin
      action_s = ACT_HOLD;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], noisy ^ ACTIVE_LOW};
    cand_d  = cand_q;
    count_d = count_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (action_s)
      ACT_RESTART: begin
        cand_d  = s1_s;
        count_d = '0;
      end
      ACT_IDLE: begin
        count_d = '0;
      end
      ACT_COMMIT: begin
        clean_d = cand_q;
        count_d = '0;
        rise_d  = cand_q;
        fall_d  = ~cand_q;
      end
      ACT_COUNT: begin
        count_d = count_q + CNT_W'(1);
      end
      ACT_HOLD: begin
        count_d = count_q;
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_VALUE}};
      cand_q  <= RESET_VALUE;
      count_q <= '0;
      clean_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs with a shared tick strobe and a
// combined any-edge indication.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  DELAY       = 16,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DELAY       (DELAY),
      .ACTIVE_LOW  (ACTIVE_LOW[i]),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .noisy (noisy[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Pulses are registered per channel, so this stays glitch-free.
  assign changed = |(rise | fall);

endmodule
